bf_top: RTL and testbench

BF_TOP -- requirements
Module: bf_top

---
 rtl/bf_pkg.sv | 23 ++
 rtl/bf_top_ds_mod.sv | 43 ++++
 rtl/bf_top.sv | 59 +++++
 tb/tb_bf_top.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared constants for the two-beam beamformer: default sizes, MAC width,
// delta-sigma thresholds and the ternary pwm codes.
package bf_pkg;

  localparam int NUM_ELEM_DEF = 8;
  localparam int IN_W_DEF     = 8;
  localparam int W_W_DEF      = 5;

  localparam int MAC_W = 15;
  localparam int ERR_W = 16;
  // One bit wider than the error state so x + e never wraps.
  localparam int V_W   = 17;

  localparam logic signed [V_W-1:0] THR_POS = V_W'(4096);
  localparam logic signed [V_W-1:0] THR_NEG = V_W'(-4096);
  localparam logic signed [V_W-1:0] FB_POS  = V_W'(8192);
  localparam logic signed [V_W-1:0] FB_NEG  = V_W'(-8192);

  localparam logic [1:0] PWM_POS  = 2'b01;
  localparam logic [1:0] PWM_NEG  = 2'b11;
  localparam logic [1:0] PWM_ZERO = 2'b00;

endpackage

// File: rtl/bf_top_ds_mod.sv
// First-order ternary delta-sigma modulator for one antenna element.
// The error state stays in [-4096, 4095], so no saturation is needed.
module ds_mod
  import bf_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [MAC_W-1:0] x_i,
  output logic [1:0]              pwm_o
);

  logic signed [ERR_W-1:0] e_q, e_d;
  logic [1:0]              pwm_q, pwm_d;
  logic signed [V_W-1:0]   v;
  logic signed [V_W-1:0]   fb;

  always_comb begin
    v     = V_W'(x_i) + V_W'(e_q);
    pwm_d = PWM_ZERO;
    fb    = '0;
    if (v >= THR_POS) begin
      pwm_d = PWM_POS;
      fb    = FB_POS;
    end else if (v < THR_NEG) begin
      pwm_d = PWM_NEG;
      fb    = FB_NEG;
    end
    e_d = ERR_W'(v - fb);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      e_q   <= '0;
      pwm_q <= PWM_ZERO;
    end else begin
      e_q   <= e_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/bf_top.sv
// Two-beam beamformer: per-element complex-weight MAC feeding a ternary
// delta-sigma modulator per lane. Define BF_PIPE_EN to register the MAC.
module bf_top
  import bf_pkg::*;
#(
  parameter int NUM_ELEM = NUM_ELEM_DEF,
  parameter int IN_W     = IN_W_DEF,
  parameter int W_W      = W_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] vin_i_1,
  input  logic signed [IN_W-1:0] vin_q_1,
  input  logic signed [IN_W-1:0] vin_i_2,
  input  logic signed [IN_W-1:0] vin_q_2,
  input  logic signed [W_W-1:0]  w_cos_1 [NUM_ELEM],
  input  logic signed [W_W-1:0]  w_sin_1 [NUM_ELEM],
  input  logic signed [W_W-1:0]  w_cos_2 [NUM_ELEM],
  input  logic signed [W_W-1:0]  w_sin_2 [NUM_ELEM],
  output logic [1:0]             pwm     [NUM_ELEM]
);

  for (genvar k = 0; k < NUM_ELEM; k++) begin : g_elem
    logic signed [MAC_W-1:0] mac_d;
    logic signed [MAC_W-1:0] x;

    // Operands are sign-extended to the MAC width; the true sum always fits.
    always_comb begin
      mac_d = MAC_W'(vin_i_1) * MAC_W'(w_cos_1[k])
            + MAC_W'(vin_q_1) * MAC_W'(w_sin_1[k])
            + MAC_W'(vin_i_2) * MAC_W'(w_cos_2[k])
            + MAC_W'(vin_q_2) * MAC_W'(w_sin_2[k]);
    end

`ifdef BF_PIPE_EN
    logic signed [MAC_W-1:0] mac_q;

    always_ff @(posedge clock) begin
      if (!reset) begin
        mac_q <= '0;
      end else begin
        mac_q <= mac_d;
      end
    end

    assign x = mac_q;
`else
    assign x = mac_d;
`endif

    ds_mod u_ds_mod (
      .clock (clock),
      .reset (reset),
      .x_i   (x),
      .pwm_o (pwm[k])
    );
  end

endmodule

// File: tb/tb_bf_top.sv
// Randomized and directed bench for bf_top with a scoreboard fed by an
// integer reference model of the MAC and ternary delta-sigma lanes.
module tb_bf_top;

  localparam int N = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic signed [7:0] vin_i_1 = '0, vin_q_1 = '0, vin_i_2 = '0, vin_q_2 = '0;
  logic signed [4:0] w_cos_1 [N];
  logic signed [4:0] w_sin_1 [N];
  logic signed [4:0] w_cos_2 [N];
  logic signed [4:0] w_sin_2 [N];
  logic [1:0]        pwm     [N];

  bf_top dut (
    .clock   (clock),
    .reset   (reset),
    .vin_i_1 (vin_i_1),
    .vin_q_1 (vin_q_1),
    .vin_i_2 (vin_i_2),
    .vin_q_2 (vin_q_2),
    .w_cos_1 (w_cos_1),
    .w_sin_1 (w_sin_1),
    .w_cos_2 (w_cos_2),
    .w_sin_2 (w_sin_2),
    .pwm     (pwm)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  // Entry: {tag, pwm lanes packed with lane k at bits [2k+1:2k]}.
  logic [2*N:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_printed = 0;
  int pos_cnt = 0;
  int neg_cnt = 0;

  // Reference model state: lane error and the MAC value seen one edge ago.
  int m_e  [N];
  int m_xd [N];

`ifdef BF_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  function automatic int model_x(input int k);
    return int'(vin_i_1) * int'(w_cos_1[k]) + int'(vin_q_1) * int'(w_sin_1[k])
         + int'(vin_i_2) * int'(w_cos_2[k]) + int'(vin_q_2) * int'(w_sin_2[k]);
  endfunction

  // Predict the edge about to happen from the current inputs, queue it, then
  // let that edge pass.
  task automatic drive(input bit rst_n, input bit tag);
    logic [2*N:0] exp_v;
    int x, xu, v, o;
    reset = rst_n;
    exp_v = '0;
    exp_v[2*N] = tag;
    for (int k = 0; k < N; k++) begin
      x  = model_x(k);
      xu = PIPE ? m_xd[k] : x;
      if (!rst_n) begin
        m_e[k]  = 0;
        m_xd[k] = 0;
        o = 0;
      end else begin
        v = xu + m_e[k];
        o = (v >= 4096) ? 1 : (v < -4096) ? -1 : 0;
        m_e[k]  = v - o * 8192;
        m_xd[k] = x;
      end
      exp_v[2*k +: 2] = (o == 1) ? 2'b01 : (o == -1) ? 2'b11 : 2'b00;
    end
    exp_q.push_back(exp_v);
    @(negedge clock);
  endtask

  task automatic set_zero();
    vin_i_1 = '0; vin_q_1 = '0; vin_i_2 = '0; vin_q_2 = '0;
    for (int k = 0; k < N; k++) begin
      w_cos_1[k] = '0; w_sin_1[k] = '0; w_cos_2[k] = '0; w_sin_2[k] = '0;
    end
  endtask

  task automatic rand_inputs();
    vin_i_1 = 8'($urandom_range(255)); vin_q_1 = 8'($urandom_range(255));
    vin_i_2 = 8'($urandom_range(255)); vin_q_2 = 8'($urandom_range(255));
    for (int k = 0; k < N; k++) begin
      w_cos_1[k] = 5'($urandom_range(31)); w_sin_1[k] = 5'($urandom_range(31));
      w_cos_2[k] = 5'($urandom_range(31)); w_sin_2[k] = 5'($urandom_range(31));
    end
  endtask

  task automatic check(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [2*N:0]   exp_v;
    logic [2*N-1:0] got;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        for (int k = 0; k < N; k++) got[2*k +: 2] = pwm[k];
        n_checks++;
        if (got === exp_v[2*N-1:0]) begin
          n_pass++;
        end else if (n_printed < 20) begin
          n_printed++;
          $display("FAIL pwm_lanes @%0t: got %h, expected %h", $time, got, exp_v[2*N-1:0]);
        end
        if (exp_v[2*N]) begin
          if (pwm[0] == 2'b01) pos_cnt++;
          if (pwm[0] == 2'b11) neg_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < N; k++) begin
      m_e[k] = 0; m_xd[k] = 0;
    end
    set_zero();

    // Reset held with nonzero inputs: lanes must stay idle.
    rand_inputs();
    vin_i_1 = 8'sd100;
    w_cos_1[0] = 5'sd15;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0);

    // All-zero inputs after release.
    set_zero();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0);

    // Single active lane, x0 = 127*15 = 1905; density measured over 8192 edges.
    vin_i_1 = 8'sd127;
    w_cos_1[0] = 5'sd15;
    for (int i = 0; i < 8192; i++) drive(1'b1, 1'b1);

    // One-cycle reset pulse mid-stream; modulator restarts from zero error.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b0);

    // Full negative drive, x = -7680 on lane 0 only, then on every lane.
    set_zero();
    vin_i_1 = -8'sd128; vin_q_1 = -8'sd128; vin_i_2 = -8'sd128; vin_q_2 = -8'sd128;
    w_cos_1[0] = 5'sd15; w_sin_1[0] = 5'sd15; w_cos_2[0] = 5'sd15; w_sin_2[0] = 5'sd15;
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b0);
    for (int k = 0; k < N; k++) begin
      w_cos_1[k] = 5'sd15; w_sin_1[k] = 5'sd15; w_cos_2[k] = 5'sd15; w_sin_2[k] = 5'sd15;
    end
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b0);

    // Cancelling beams on lane 3.
    set_zero();
    vin_i_1 = 8'sd64; w_cos_1[3] = 5'sd15;
    vin_q_2 = 8'sd64; w_sin_2[3] = -5'sd15;
    for (int i = 0; i < 50; i++) drive(1'b1, 1'b0);

    // Random inputs, held for random stretches, with occasional reset pulses.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) rand_inputs();
      drive(($urandom_range(99) != 0), 1'b0);
    end
    set_zero();
    drive(1'b1, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    check("scoreboard_drained", exp_q.size(), 0, 0);
    check("lane0_pos_density", pos_cnt, 1904, 1906);
    check("lane0_no_neg", neg_cnt, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
